// File: rtl/mul8_pkg.sv
// Shared definitions for the sequential 8x8 multiplier.
// Holds the FSM state encoding and the fixed datapath widths.
package mul8_pkg;

   localparam int MUL_W  = 8;
   localparam int PROD_W = 16;
   localparam int NIB_W  = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      EVAL   = 3'd1,
      ADD_LO = 3'd2,
      ADD_HI = 3'd3,
      SHIFT  = 3'd4,
      DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/mul8_seq_ctrl_add4.sv
// 4-bit carry-lookahead adder slice shared by both nibble passes.
// Ports: a, b (4-bit addends), cin -> s (4-bit sum), cout.
module add4
   import mul8_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic             cout
);

   logic [NIB_W-1:0] p;
   logic [NIB_W-1:0] g;
   logic [NIB_W:0]   c;

   assign p = a ^ b;
   assign g = a & b;

   // Flat lookahead terms: each carry depends only on p, g and cin.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0])
               | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s    = p ^ c[NIB_W-1:0];
   assign cout = c[NIB_W];

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned shift-add multiplier over one shared add4 slice.
// Ports: clk, rst_n (sync, active low), start, a, b -> busy, done, product.
module mul8_seq_ctrl
   import mul8_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [MUL_W-1:0]  a,
   input  logic [MUL_W-1:0]  b,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   state_t            state;
   logic [MUL_W-1:0]  mcand;
   logic [PROD_W-1:0] acc;
   logic              ext;
   logic              c_lo;
   logic [2:0]        cnt;

   logic [NIB_W-1:0]  add_a;
   logic [NIB_W-1:0]  add_b;
   logic              add_cin;
   logic [NIB_W-1:0]  add_s;
   logic              add_cout;

   logic [PROD_W-1:0] acc_sh;

   // ext holds the 9th bit of the high add and shifts in at the top.
   assign acc_sh = {ext, acc[PROD_W-1:1]};

   // Adder inputs stay at zero outside the two add states.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (state)
         ADD_LO: begin
            add_a = acc[11:8];
            add_b = mcand[3:0];
         end
         ADD_HI: begin
            add_a   = acc[15:12];
            add_b   = mcand[7:4];
            add_cin = c_lo;
         end
         default: ;
      endcase
   end

   add4 u_add4 (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .s    (add_s),
      .cout (add_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         mcand   <= '0;
         acc     <= '0;
         ext     <= 1'b0;
         c_lo    <= 1'b0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= a;
                  acc   <= {{MUL_W{1'b0}}, b};
                  ext   <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= EVAL;
               end
            end
            EVAL: begin
               state <= acc[0] ? ADD_LO : SHIFT;
            end
            ADD_LO: begin
               acc[11:8] <= add_s;
               c_lo      <= add_cout;
               state     <= ADD_HI;
            end
            ADD_HI: begin
               acc[15:12] <= add_s;
               ext        <= add_cout;
               state      <= SHIFT;
            end
            SHIFT: begin
               acc <= acc_sh;
               ext <= 1'b0;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  product <= acc_sh;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  state <= EVAL;
               end
            end
            DONE: begin
               done <= 1'b0;
               // A start here chains straight into the next operation.
               if (start) begin
                  mcand <= a;
                  acc   <= {{MUL_W{1'b0}}, b};
                  ext   <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= EVAL;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
